// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver: HUB-75 1/32-scan panel driver with binary-code modulation.
// Reads the dual-bank line RAM and paces the line generator one row ahead.
module hub75_scan_driver #(
   parameter int bit_depth = 8,
   parameter int oe_base_cycles = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   output logic                   generator_start,
   output logic [4:0]             generator_y,
   input  logic                   generator_is_idle,
   output logic [9:0]             frame_count,
   output logic [6:0]             read_address,
   input  logic [6*bit_depth-1:0] read_data,
   output logic                   hub_r0,
   output logic                   hub_g0,
   output logic                   hub_b0,
   output logic                   hub_r1,
   output logic                   hub_g1,
   output logic                   hub_b1,
   output logic                   hub_clk,
   output logic                   hub_lat,
   output logic                   hub_oe_n,
   output logic [4:0]             hub_addr
);
   localparam int pw = bit_depth > 1 ? $clog2(bit_depth) : 1;
   localparam int max_len = oe_base_cycles << (bit_depth - 1);
   localparam int cw = max_len > 130 ? $clog2(max_len) : 8;
   typedef enum logic [2:0] {kPrime, kPrimeWait, kRowStart, kShift, kLatch, kDisplay, kRowWait} state_t;
   state_t state;
   logic [4:0] row;
   logic [pw-1:0] plane;
   logic [cw-1:0] cnt, cnt_next, disp_last;
   logic [5:0] colour;
   logic [5:0][bit_depth-1:0] chans;
   assign chans = read_data;
   assign cnt_next = cnt + cw'(1);
   assign disp_last = cw'((oe_base_cycles << plane) - 1);
   assign {hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1} = colour;
   // kShift: address x at cycle 2x, RAM data at 2x+1, bits out at 2x+2 (clk low) and 2x+3 (clk high)
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= kPrime;
         row <= '0;
         plane <= '0;
         cnt <= '0;
         colour <= '0;
         frame_count <= '0;
         generator_start <= 1'b0;
         generator_y <= '0;
         read_address <= '0;
         hub_clk <= 1'b0;
         hub_lat <= 1'b0;
         hub_oe_n <= 1'b1;
         hub_addr <= '0;
      end else begin
         generator_start <= 1'b0;
         case (state)
            kPrime: begin
               generator_start <= 1'b1;
               generator_y <= '0;
               state <= kPrimeWait;
            end
            kPrimeWait: if (!generator_start && generator_is_idle) begin
               generator_start <= 1'b1;
               generator_y <= row + 5'd1;
               state <= kRowStart;
            end
            kRowStart: begin
               plane <= '0;
               cnt <= '0;
               read_address <= {row[0], 6'd0};
               state <= kShift;
            end
            kShift: if (cnt == cw'(129)) begin
               hub_clk <= 1'b0;
               hub_lat <= 1'b1;
               hub_addr <= row;
               state <= kLatch;
            end else begin
               cnt <= cnt_next;
               read_address <= {row[0], cnt_next[6:1]};
               if (cnt_next >= cw'(2)) hub_clk <= cnt_next[0];
               if (cnt_next >= cw'(2) && !cnt_next[0])
                  colour <= {chans[5][plane], chans[4][plane], chans[3][plane],
                             chans[2][plane], chans[1][plane], chans[0][plane]};
            end
            kLatch: begin
               hub_lat <= 1'b0;
               hub_oe_n <= 1'b0;
               cnt <= '0;
               state <= kDisplay;
            end
            kDisplay: if (cnt == disp_last) begin
               hub_oe_n <= 1'b1;
               cnt <= '0;
               read_address <= {row[0], 6'd0};
               if (plane == pw'(bit_depth - 1)) state <= kRowWait;
               else begin
                  plane <= plane + pw'(1);
                  state <= kShift;
               end
            end else cnt <= cnt_next;
            kRowWait: if (generator_is_idle) begin
               row <= row + 5'd1;
               generator_start <= 1'b1;
               generator_y <= row + 5'd2;
               if (row == 5'd30) frame_count <= frame_count + 10'd1;
               state <= kRowStart;
            end
            default: state <= kPrime;
         endcase
      end
endmodule

// File: doc/hub75_scan_driver.md
# hub75_scan_driver

Consumer side of the line-buffer path: reads pixel words written by the pixel generator, serialises them onto a HUB-75 panel (64 columns, 1/32 scan, two half-panels) with binary-code modulation, and paces the generator by issuing per-row `start` requests. It owns the row counter and `frame_count` that feed the generator. Sits between the dual-bank line RAM and the panel pins.

## Interface
- `bit_depth`, 8: colour bits per channel and number of BCM planes.
- `oe_base_cycles`, 4: display time of plane 0; plane k displays `oe_base_cycles << k` cycles.
- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `generator_start` out 1: one-cycle request to fill the line buffer for row `generator_y`.
- `generator_y` out 5: row the generator fills; bank = `generator_y[0]`.
- `generator_is_idle` in 1: generator finished its fill.
- `frame_count` out 10: frame number for the generator; wraps 1023→0.
- `read_address` out 7: `{row[0], x}`.
- `read_data` in 48: registered RAM output, valid 1 cycle after address. [47:40] R0, [39:32] G0, [31:24] B0 (top row), [23:16] R1, [15:8] G1, [7:0] B1 (row+32).
- `hub_r0/g0/b0/r1/g1/b1` out 1 each: serial colour bits.
- `hub_clk` out 1: panel shift clock; panel samples on rising edge.
- `hub_lat` out 1: latch pulse.
- `hub_oe_n` out 1: output enable, active low.
- `hub_addr` out 5: panel row select.

## Operation
- States: kPrime, kPrimeWait, kRowStart, kShift, kLatch, kDisplay, kRowWait.
- Reset: state kPrime, row 0, plane 0; all outputs 0 except `hub_oe_n`=1. Asynchronous reset anywhere drops to these values immediately.
- kPrime: `generator_start`=1, `generator_y`=0 for one cycle → kPrimeWait.
- kPrimeWait: `generator_is_idle` is not sampled in the start cycle; from the next cycle, once idle=1 → kRowStart.
- kRowStart (1 cycle): `generator_start`=1, `generator_y`=(row+1) mod 32; plane←0 → kShift.
- kShift: x=0..63; column x read at `{row[0], x}`; `hub_*` colour = bit `plane` of the matching bytes. → kLatch after column 63 clocked.
- kLatch (1 cycle): `hub_lat`=1, `hub_addr`←row, `hub_oe_n`=1.
- kDisplay: `hub_oe_n`=0 for `oe_base_cycles << plane` cycles. Then plane<bit_depth-1: plane+1 → kShift; else → kRowWait.
- kRowWait: hold `hub_oe_n`=1; when `generator_is_idle`=1, row←(row+1) mod 32 → kRowStart. Stalls indefinitely if the generator is busy.
- `frame_count` increments only on the kRowWait→kRowStart transition into row 31, so the start for y=0 already carries the new frame number; stable otherwise.
- `hub_addr` changes only while `hub_oe_n`=1. Generator never writes bank row[0] while that row is being shifted.

## Timing
- Per column: 2 output cycles — `hub_clk`=0 with new colour bits, then `hub_clk`=1 with bits held. Colour for column x appears 2 cycles after `read_address`={row[0],x}.
- kShift length: 130 cycles (2 pipeline + 128); exactly 64 `hub_clk` rising edges per plane.
- Plane k: 130 + 1 + (`oe_base_cycles`<<k) cycles; default row without stall: 1 + 8·131 + 1020 + 1 = 2070 cycles.
- `generator_start` never asserted on two consecutive cycles; never asserted while `generator_is_idle`=0.
- `hub_lat` and `hub_oe_n`=0 never coincide; `hub_clk`=0 in kLatch and kDisplay.

## Test plan
- Reset: all outputs 0, `hub_oe_n`=1; release → `generator_start`=1,`generator_y`=0 next cycle; idle held 0 for 64 cycles → no further start until idle=1, then start with y=1.
- Shift plane 0, `read_data`=48'hFF00FF_00FF00 constant → 64 `hub_clk` rising edges with r0=1,g0=0,b0=1,r1=0,g1=1,b1=0; `read_address` sweeps 0..63 (row 0).
- Plane timing: `hub_lat` 1 cycle after last shift; `hub_oe_n`=0 exactly 4 cycles for plane 0, 512 for plane 7; colour = bit 7 with `read_data`=8'h80 bytes.
- Row advance: row 1 reads addresses 64..127, `hub_addr`=1 changes only during `hub_oe_n`=1; start for y=2 issued.
- Frame wrap: after row 30 → `frame_count` 0→1 entering row 31, start with y=0; row 31→0 without further increment; 1024 frames wrap to 0.
- Reset asserted mid-kDisplay plane 5 → outputs to reset values same cycle; after release, kPrime sequence restarts from row 0.
